// File: rtl/vga_timing.sv
// 640x480@60 VGA raster generator: pixel/line counters, sync pulses, active flag and strobes.
// Optional completed-frame counter on output frame_count, enabled by defining VGA_FRAME_CNT_EN.
module vga_timing #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        clk_25,
   input  logic        rst,
   output logic [9:0]  sx,
   output logic [9:0]  sy,
   output logic        active_pixel,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
      $error("vga_timing: H_TOTAL=%0d V_TOTAL=%0d, both must be <= 1024", H_TOTAL, V_TOTAL);
   end

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   // 11-bit window bounds so a 1024-wide field cannot alias to zero
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_LO  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_HI  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_LO  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_HI  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0]  hc, vc;
   logic [10:0] hc_x, vc_x;
   logic        h_act, v_act, h_win, v_win;

   assign hc_x  = {1'b0, hc};
   assign vc_x  = {1'b0, vc};
   assign h_act = hc_x < H_ACT;
   assign v_act = vc_x < V_ACT;
   assign h_win = (hc_x >= HS_LO) && (hc_x <= HS_HI);
   assign v_win = (vc_x >= VS_LO) && (vc_x <= VS_HI);

   always_ff @(posedge clk_25) begin
      if (rst) begin
         hc <= '0;
         vc <= '0;
      end else if (hc == H_LAST) begin
         hc <= '0;
         vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
      end else begin
         hc <= hc + 10'd1;
      end
   end

   // Every output is registered from the same hc/vc, so all describe one pixel.
   // vsync follows vc, which only moves when hc wraps, so its edges land at sx=0.
   always_ff @(posedge clk_25) begin
      if (rst) begin
         sx           <= '0;
         sy           <= '0;
         active_pixel <= 1'b0;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
         hsync        <= ~SYNC_POL;
         vsync        <= ~SYNC_POL;
      end else begin
         sx           <= hc;
         sy           <= vc;
         active_pixel <= h_act && v_act;
         line_start   <= (hc == '0);
         frame_start  <= (hc == '0) && (vc == '0);
         hsync        <= h_win ? SYNC_POL : ~SYNC_POL;
         vsync        <= v_win ? SYNC_POL : ~SYNC_POL;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic first_seen;

   // The frame beginning right after reset is not a completed frame.
   always_ff @(posedge clk_25) begin
      if (rst) begin
         frame_count <= '0;
         first_seen  <= 1'b0;
      end else if ((hc == '0) && (vc == '0)) begin
         first_seen <= 1'b1;
         if (first_seen) frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates the 640x480@60 Hz VGA raster for the display path: free-running horizontal and vertical pixel counters, sync pulses, an active-video flag and line/frame strobes. It runs on the 25 MHz pixel clock and sits directly upstream of the pong renderer. That renderer consumes `sx`, `sy` and `active_pixel` and keys its ball animation off position (`sx=0`, `sy=524`). `hsync` and `vsync` go to the board connector, aligned with the renderer's registered RGB.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: hsync pulse width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vsync pulse width, lines
- `V_BP`, 33: vertical back porch, lines
- `SYNC_POL`, 0: sync asserted level (0 = active-low)

Ports:
- `clk_25`  in  1  pixel clock, 25 MHz (nominal 25.175)
- `rst`  in  1  synchronous, active-high reset
- `sx`  out  10  horizontal position, 0..H_TOTAL-1
- `sy`  out  10  vertical position, 0..V_TOTAL-1
- `active_pixel`  out  1  high when `sx<H_ACTIVE && sy<V_ACTIVE`
- `hsync`  out  1  horizontal sync, level per `SYNC_POL`
- `vsync`  out  1  vertical sync, level per `SYNC_POL`
- `line_start`  out  1  one-cycle pulse when `sx==0`
- `frame_start`  out  1  one-cycle pulse when `sx==0 && sy==0`
- `frame_count`  out  16  completed-frame count (only with `VGA_FRAME_CNT_EN`)

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Elaboration check: H_TOTAL and V_TOTAL must both be ≤1024. If either exceeds 1024, elaboration fails with `$error`.
- Internal counters `hc`, `vc`, both 10 bits.
  - `hc` increments every cycle. At H_TOTAL-1 it wraps to 0.
  - `vc` increments only when `hc==H_TOTAL-1`. At `vc==V_TOTAL-1` with `hc==H_TOTAL-1`, it wraps to 0.
- Sync windows:
  - hsync asserted for `hc` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync asserted for `vc` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
  - vsync is line-granular: its edges occur at `hc==0`.
- All outputs are registered from `hc`/`vc`, and every output in a given cycle describes the same pixel.
- Reset (while `rst` high):
  - `hc=0`, `vc=0`, `sx=0`, `sy=0`.
  - `active_pixel=0`, `line_start=0`, `frame_start=0`.
  - `hsync` and `vsync` are driven deasserted (`~SYNC_POL`).
  - `frame_count=0`.
- Reset asserted mid-frame aborts the frame. The next frame starts cleanly at (0,0); no partial sync pulse is stretched or repeated.
- There is no enable input: the raster free-runs from reset release.

## Timing
- Output latency: one cycle. Outputs after edge n reflect the counter value held before edge n.
- First edge with `rst` low presents `sx=0`, `sy=0`, `active_pixel=1`, `line_start=1`, `frame_start=1`.
- Each subsequent edge advances `sx` by exactly 1.
- Line wrap:
  - the cycle showing `sx=799` is followed by `sx=0` with `sy+1`;
  - the cycle showing `sy=524, sx=799` is followed by (0,0) with `frame_start=1`.
- `line_start` fires once per 800 cycles. `frame_start` fires once per 420,000 cycles.
- `active_pixel` falls on the cycle presenting `sx=640`. It stays low for all of lines 480..524.

## Configuration
- `VGA_FRAME_CNT_EN` defined:
  - `frame_count` port exists;
  - it increments by 1 in the same cycle `frame_start` is presented, excluding the first `frame_start` after reset;
  - it wraps 65535→0.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Release reset after 5 cycles → first output cycle shows (0,0), `active_pixel=1`, `frame_start=1`, `hsync=vsync=1`.
- Run one line → `hsync=0` exactly for `sx` 656..751 (96 cycles); `active_pixel` high for exactly 640 cycles; `line_start` period is 800.
- Run two frames → `vsync=0` for `sy` 490..491 (1600 cycles); (524,799) is followed by (0,0); `frame_start` pulses are 420,000 cycles apart.
- Assert `rst` for 1 cycle at `sx=700`, `sy=300` → all outputs hold reset values during that cycle; the next cycle presents (0,0) with `frame_start=1`.
- With `VGA_FRAME_CNT_EN`: run 3 full frames → `frame_count` steps 0→1→2→3, each step coinciding with `frame_start`. Force the counter to 65535, run one frame → 0.
- Parameter override `H_ACTIVE=800`, `H_BP=200` (H_TOTAL=1112) → elaboration fails.
